// File: rtl/surf4_pps_pkg.sv
// Shared encodings and helpers for the surf4 PPS conditioning stage.
package surf4_pps_pkg;

  // PPS source selection as presented on pps_sel_i
  typedef enum logic [1:0] {
    PPS_SEL_EXT = 2'b00,
    PPS_SEL_INT = 2'b01,
    PPS_SEL_SW  = 2'b10,
    PPS_SEL_OFF = 2'b11
  } pps_sel_t;

  // External edge qualification states
  typedef enum logic [1:0] {
    S_WAIT    = 2'b00,
    S_FILT    = 2'b01,
    S_REFRACT = 2'b10
  } filt_state_t;

  // Loss threshold is period + period/8
  localparam int LOSS_SHIFT = 3;

  // Effective cycles-per-second: 0 selects the reset default, tiny values clamp to 2
  function automatic logic [31:0] eff_period(input logic [31:0] period,
                                             input logic [31:0] period_rst);
    logic [31:0] p;
    p = (period == 32'd0) ? period_rst : period;
    if (p < 32'd2) begin
      p = 32'd2;
    end
    return p;
  endfunction

endpackage

// File: rtl/pps_sync_filter.sv
// PPS pad synchroniser, rising-edge detect and glitch filter.
// Emits a registered one-cycle accept pulse once FILT_CYCLES consecutive
// high samples follow a rising edge; further edges are ignored until the
// refractory window (signalled by the parent) has elapsed.
module pps_sync_filter
  import surf4_pps_pkg::*;
#(
  parameter int SYNC_STAGES = 3,
  parameter int FILT_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad,
  input  logic en,
  input  logic refract_done,
  output logic accept
);

  localparam int CW = $clog2(FILT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_prev_reg;
  logic                   sync;
  logic                   rise;
  filt_state_t            state_reg, state_next;
  logic [CW-1:0]          filt_cnt_reg, filt_cnt_next;
  logic                   accept_reg, accept_next;

  assign sync   = sync_reg[SYNC_STAGES-1];
  assign rise   = sync & ~sync_prev_reg;
  assign accept = accept_reg;

  // Metastability chain plus one delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg      <= '0;
      sync_prev_reg <= 1'b0;
    end else begin
      sync_reg      <= {sync_reg[SYNC_STAGES-2:0], pad};
      sync_prev_reg <= sync;
    end
  end

  // FSM and filter counter state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_WAIT;
      filt_cnt_reg <= '0;
      accept_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      filt_cnt_reg <= filt_cnt_next;
      accept_reg   <= accept_next;
    end
  end

  // Next-state logic; the count check precedes the level check so a full
  // run of high samples is accepted even if the pad drops right after
  always_comb begin
    state_next    = state_reg;
    filt_cnt_next = filt_cnt_reg;
    accept_next   = 1'b0;
    if (!en) begin
      state_next    = S_WAIT;
      filt_cnt_next = '0;
    end else begin
      case (state_reg)
        S_WAIT: begin
          if (rise) begin
            state_next    = S_FILT;
            filt_cnt_next = CW'(1);
          end
        end
        S_FILT: begin
          if (filt_cnt_reg == CW'(FILT_CYCLES)) begin
            accept_next   = 1'b1;
            state_next    = S_REFRACT;
            filt_cnt_next = '0;
          end else if (sync) begin
            filt_cnt_next = filt_cnt_reg + CW'(1);
          end else begin
            state_next    = S_WAIT;
            filt_cnt_next = '0;
          end
        end
        S_REFRACT: begin
          // The parent's cycle counter only clears the cycle after accept,
          // so its stale value must not end the window on that first cycle
          if (refract_done && !accept_reg) begin
            state_next = S_WAIT;
          end
        end
        default: begin
          state_next    = S_WAIT;
          filt_cnt_next = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/surf4_pps_gen.sv
// PPS conditioning stage: source select (external / internal / software /
// off), one-cycle PPS pulse, seconds counter, external period measurement
// and loss detection with interrupt.
// Optional build macro PPS_HOLDOVER_EN: while the external PPS is lost,
// keep emitting pulses every effective period starting at the loss cycle.
module surf4_pps_gen
  import surf4_pps_pkg::*;
#(
  parameter int          SYNC_STAGES = 3,
  parameter int          FILT_CYCLES = 8,
  parameter logic [31:0] PERIOD_RST  = 32'd100000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  pps_sel_i,
  input  logic        sw_pps_i,
  input  logic [31:0] period_i,
  input  logic        PPS,
  output logic        pps_o,
  output logic [31:0] pps_count_o,
  output logic [31:0] last_period_o,
  output logic        period_valid_o,
  output logic        pps_lost_o,
  output logic        pps_int_o
);

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic [1:0]  rst_bridge_reg;
  logic        rst_n;
  pps_sel_t    sel_reg;
  logic        mode_change;
  logic        accept;
  logic        filt_en;
  logic [31:0] eff;
  logic [32:0] loss_thr;
  logic        refract_done;

  logic [31:0] cyc_cnt_reg, cyc_cnt_next;
  logic [31:0] gen_cnt_reg, gen_cnt_next;
  logic [31:0] count_reg, count_next;
  logic [31:0] last_period_reg, last_period_next;
  logic        seen_reg, seen_next;
  logic        valid_reg, valid_next;
  logic        lost_reg, lost_next;
  logic        pps_reg, pps_next;
  logic        int_reg, int_next;
  logic        sw_prev_reg;

  // Reset bridge: assert immediately, release two clocks after rst_i rises
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rst_bridge_reg <= 2'b00;
    end else begin
      rst_bridge_reg <= {rst_bridge_reg[0], 1'b1};
    end
  end

  assign rst_n        = rst_bridge_reg[1];
  assign mode_change  = (pps_sel_t'(pps_sel_i) != sel_reg);
  assign filt_en      = (sel_reg == PPS_SEL_EXT) && !mode_change;
  assign eff          = eff_period(period_i, PERIOD_RST);
  assign loss_thr     = {1'b0, eff} + {1'b0, (eff >> LOSS_SHIFT)};
  assign refract_done = (cyc_cnt_reg >= (eff >> 1));

  pps_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_CYCLES (FILT_CYCLES)
  ) u_filter (
    .clk          (clk_i),
    .rst_n        (rst_n),
    .pad          (PPS),
    .en           (filt_en),
    .refract_done (refract_done),
    .accept       (accept)
  );

  // Counters, measurement, loss and pulse generation
  always_comb begin
    cyc_cnt_next     = cyc_cnt_reg;
    gen_cnt_next     = gen_cnt_reg;
    last_period_next = last_period_reg;
    seen_next        = seen_reg;
    valid_next       = valid_reg;
    lost_next        = lost_reg;
    pps_next         = 1'b0;
    if (mode_change) begin
      // Generator restarts so the first internal pulse is a full period
      // after the new mode takes effect; count and last period survive
      cyc_cnt_next = '0;
      gen_cnt_next = eff - 32'd1;
      seen_next    = 1'b0;
      valid_next   = 1'b0;
      lost_next    = 1'b0;
    end else begin
      if (accept) begin
        cyc_cnt_next = '0;
      end else if (cyc_cnt_reg != CNT_MAX) begin
        cyc_cnt_next = cyc_cnt_reg + 32'd1;
      end
      case (sel_reg)
        PPS_SEL_EXT: begin
          if (accept) begin
            pps_next         = 1'b1;
            last_period_next = (cyc_cnt_reg == CNT_MAX) ? CNT_MAX : cyc_cnt_reg + 32'd1;
            seen_next        = 1'b1;
            lost_next        = 1'b0;
            if (seen_reg) begin
              valid_next = 1'b1;
            end
          end else if (seen_reg && ({1'b0, cyc_cnt_next} == loss_thr)) begin
            lost_next = 1'b1;
          end
`ifdef PPS_HOLDOVER_EN
          // Holdover pulses: one at the loss cycle, then every period
          if (!accept) begin
            if (lost_next && !lost_reg) begin
              pps_next     = 1'b1;
              gen_cnt_next = eff - 32'd1;
            end else if (lost_reg) begin
              if (gen_cnt_reg == 32'd0) begin
                pps_next     = 1'b1;
                gen_cnt_next = eff - 32'd1;
              end else begin
                gen_cnt_next = gen_cnt_reg - 32'd1;
              end
            end
          end
`else
          // Without holdover, loss is reported by flag and interrupt only
`endif
        end
        PPS_SEL_INT: begin
          if (gen_cnt_reg == 32'd0) begin
            pps_next     = 1'b1;
            gen_cnt_next = eff - 32'd1;
          end else begin
            gen_cnt_next = gen_cnt_reg - 32'd1;
          end
        end
        PPS_SEL_SW: begin
          pps_next = sw_pps_i & ~sw_prev_reg;
        end
        default: begin
          pps_next = 1'b0;
        end
      endcase
    end
  end

  assign count_next = pps_next ? count_reg + 32'd1 : count_reg;
  assign int_next   = pps_next | (lost_next & ~lost_reg);

  // Registered state and outputs
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sel_reg         <= PPS_SEL_EXT;
      sw_prev_reg     <= 1'b0;
      cyc_cnt_reg     <= '0;
      gen_cnt_reg     <= '0;
      count_reg       <= '0;
      last_period_reg <= '0;
      seen_reg        <= 1'b0;
      valid_reg       <= 1'b0;
      lost_reg        <= 1'b0;
      pps_reg         <= 1'b0;
      int_reg         <= 1'b0;
    end else begin
      sel_reg         <= pps_sel_t'(pps_sel_i);
      sw_prev_reg     <= sw_pps_i;
      cyc_cnt_reg     <= cyc_cnt_next;
      gen_cnt_reg     <= gen_cnt_next;
      count_reg       <= count_next;
      last_period_reg <= last_period_next;
      seen_reg        <= seen_next;
      valid_reg       <= valid_next;
      lost_reg        <= lost_next;
      pps_reg         <= pps_next;
      int_reg         <= int_next;
    end
  end

  assign pps_o          = pps_reg;
  assign pps_count_o    = count_reg;
  assign last_period_o  = last_period_reg;
  assign period_valid_o = valid_reg;
  assign pps_lost_o     = lost_reg;
  assign pps_int_o      = int_reg;

endmodule
